// File: rtl/y86_register_file_if.sv
// y86_register_file_if: write-back, decode-read and trace signals of the Y86-64 register file.
interface y86_register_file_if #(parameter int WIDTH = 64);
    logic             wr_en;
    logic [3:0]       dstE;
    logic [WIDTH-1:0] valE;
    logic [3:0]       dstM;
    logic [WIDTH-1:0] valM;
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [WIDTH-1:0] rsp_out;
    logic [15:0]      wr_count;

    modport master (
        output wr_en, dstE, valE, dstM, valM, srcA, srcB,
        input  valA, valB, rsp_out, wr_count
    );

    modport slave (
        input  wr_en, dstE, valE, dstM, valM, srcA, srcB,
        output valA, valB, rsp_out, wr_count
    );
endinterface

// File: rtl/y86_register_file.sv
// y86_register_file: Y86-64 registers 0-14, two sync write ports (M wins on conflict),
// two combinational read ports with optional write bypass, saturating write counter.
module y86_register_file #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] RSP_INIT = '0,
    parameter bit               BYPASS   = 1'b0
) (
    input logic clk,
    input logic rst,
    y86_register_file_if.slave rf
);
    localparam logic [3:0] RNONE = 4'hF;

    logic [WIDTH-1:0] regs [0:14];
    logic             e_ok, m_ok, live;
    logic [1:0]       n_wr;
    logic [16:0]      sum;

    always_comb begin
        e_ok = rf.dstE != RNONE;
        m_ok = rf.dstM != RNONE;
        live = rf.wr_en && !rst;
        // same destination on both ports is a single committed write
        n_wr = (e_ok && m_ok) ? ((rf.dstE == rf.dstM) ? 2'd1 : 2'd2) : {1'b0, e_ok | m_ok};
        sum  = {1'b0, rf.wr_count} + {15'b0, n_wr};
        rf.valA = (BYPASS && live && m_ok && rf.srcA == rf.dstM) ? rf.valM :
                  (BYPASS && live && e_ok && rf.srcA == rf.dstE) ? rf.valE :
                  (rf.srcA == RNONE) ? '0 : regs[rf.srcA];
        rf.valB = (BYPASS && live && m_ok && rf.srcB == rf.dstM) ? rf.valM :
                  (BYPASS && live && e_ok && rf.srcB == rf.dstE) ? rf.valE :
                  (rf.srcB == RNONE) ? '0 : regs[rf.srcB];
    end

    assign rf.rsp_out = regs[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) regs[i] <= (i == 4) ? RSP_INIT : '0;
            rf.wr_count <= '0;
        end else if (rf.wr_en) begin
            if (e_ok) regs[rf.dstE] <= rf.valE;
            // M port is assigned last so it wins a same-register conflict
            if (m_ok) regs[rf.dstM] <= rf.valM;
            rf.wr_count <= sum[16] ? 16'hFFFF : sum[15:0];
        end
    end
endmodule

// File: tb/tb_y86_register_file.sv
// tb_y86_register_file: random and directed checks of the register file (BYPASS=0 and BYPASS=1)
// against a behavioural array model.
module tb_y86_register_file;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    y86_register_file_if #(.WIDTH(64)) ifn();
    y86_register_file_if #(.WIDTH(64)) ifb();

    y86_register_file #(.WIDTH(64), .RSP_INIT(64'h1000), .BYPASS(1'b0)) dut_n (.clk(clk), .rst(rst), .rf(ifn));
    y86_register_file #(.WIDTH(64), .RSP_INIT(64'h1000), .BYPASS(1'b1)) dut_b (.clk(clk), .rst(rst), .rf(ifb));

    logic [63:0] m [0:14];
    int          cnt;
    bit          armed = 0;
    int          tests = 0;
    int          fails = 0;

    logic        r_we;
    logic [3:0]  r_de, r_dm, r_sa, r_sb;
    logic [63:0] r_ve, r_vm;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [3:0] src, input bit byp);
        if (src == 4'hF) return 64'h0;
        if (byp && r_we && !rst) begin
            if (r_dm == src) return r_vm;
            if (r_de == src) return r_ve;
        end
        return m[src];
    endfunction

    task automatic set(input logic r, input logic we, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm, input logic [3:0] sa, input logic [3:0] sb);
        rst = r; r_we = we; r_de = de; r_ve = ve; r_dm = dm; r_vm = vm; r_sa = sa; r_sb = sb;
        ifn.wr_en = we; ifn.dstE = de; ifn.valE = ve; ifn.dstM = dm; ifn.valM = vm; ifn.srcA = sa; ifn.srcB = sb;
        ifb.wr_en = we; ifb.dstE = de; ifb.valE = ve; ifb.dstM = dm; ifb.valM = vm; ifb.srcA = sa; ifb.srcB = sb;
    endtask

    // model commit: the set of registers written is what counts, M data overrides E data
    task automatic tick();
        int n;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 15; i++) m[i] = 64'h0;
            m[4] = 64'h1000;
            cnt = 0;
            armed = 1;
        end else if (r_we) begin
            n = 0;
            if (r_de != 4'hF) begin m[r_de] = r_ve; n++; end
            if (r_dm != 4'hF) begin
                if (r_dm != r_de) n++;
                m[r_dm] = r_vm;
            end
            cnt = (cnt + n > 65535) ? 65535 : cnt + n;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("n_valA", ifn.valA, exp_rd(r_sa, 0));
            check("n_valB", ifn.valB, exp_rd(r_sb, 0));
            check("b_valA", ifb.valA, exp_rd(r_sa, 1));
            check("b_valB", ifb.valB, exp_rd(r_sb, 1));
            check("n_rsp", ifn.rsp_out, m[4]);
            check("b_rsp", ifb.rsp_out, m[4]);
            check("n_cnt", {48'h0, ifn.wr_count}, 64'(cnt));
            check("b_cnt", {48'h0, ifb.wr_count}, 64'(cnt));
        end
    end

    initial begin
        set(1, 0, 4'hF, 0, 4'hF, 0, 4'hF, 4'hF);
        tick(); tick();
        set(0, 0, 4'hF, 0, 4'hF, 0, 4, 0);
        #1;
        check("rst_valA", ifn.valA, 64'h1000);
        check("rst_valB", ifn.valB, 64'h0);
        check("rst_rsp", ifn.rsp_out, 64'h1000);
        check("rst_cnt", {48'h0, ifn.wr_count}, 64'h0);

        set(0, 1, 2, 64'hAAAA, 7, 64'h5555, 2, 7);
        #1;
        check("pre_n_valA", ifn.valA, 64'h0);
        check("byp_e_valA", ifb.valA, 64'hAAAA);
        check("byp_m_valB", ifb.valB, 64'h5555);
        tick();
        check("dual_valA", ifn.valA, 64'hAAAA);
        check("dual_valB", ifn.valB, 64'h5555);
        check("dual_cnt", {48'h0, ifn.wr_count}, 64'h2);

        set(0, 1, 4, 64'h0FF8, 4, 64'hBEEF, 4, 2);
        #1;
        check("byp_conflict", ifb.valA, 64'hBEEF);
        tick();
        check("conf_rsp", ifn.rsp_out, 64'hBEEF);
        check("conf_cnt", {48'h0, ifn.wr_count}, 64'h3);

        set(0, 1, 15, 64'hDEAD, 15, 64'hDEAD, 15, 4);
        tick();
        check("rnone_valA", ifn.valA, 64'h0);
        check("rnone_valB", ifn.valB, 64'hBEEF);
        check("rnone_cnt", {48'h0, ifn.wr_count}, 64'h3);

        set(0, 0, 3, 64'h1, 15, 0, 3, 2);
        #1;
        check("gate_byp", ifb.valA, 64'h0);
        tick();
        check("gate_valA", ifn.valA, 64'h0);
        check("gate_cnt", {48'h0, ifn.wr_count}, 64'h3);

        set(0, 1, 3, 64'h5, 15, 0, 3, 2);
        tick();
        check("w3_valA", ifn.valA, 64'h5);
        set(1, 1, 3, 64'h9, 15, 0, 3, 4);
        #1;
        check("rst_nobyp", ifb.valA, 64'h5);
        tick();
        check("rstpri_valA", ifn.valA, 64'h0);
        check("rstpri_rsp", ifn.valB, 64'h1000);
        check("rstpri_cnt", {48'h0, ifn.wr_count}, 64'h0);

        set(0, 1, 5, 64'h77, 15, 0, 5, 5);
        #1;
        check("byp_valA", ifb.valA, 64'h77);
        check("nobyp_old", ifn.valA, 64'h0);
        tick();
        check("after_valA", ifn.valA, 64'h77);

        for (int i = 0; i < 600; i++) begin
            set(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)), {$urandom, $urandom},
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 6)),
                {$urandom, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            tick();
        end

        for (int i = 0; i < 32800; i++) begin
            set(0, 1, 4'(i % 7), 64'(i), 4'(7 + i % 7), 64'(~i), 4'(i % 15), 4'((i + 3) % 15));
            tick();
        end
        check("sat_cnt", {48'h0, ifn.wr_count}, 64'hFFFF);
        tick();
        check("sat_hold", {48'h0, ifn.wr_count}, 64'hFFFF);

        set(0, 0, 4'hF, 0, 4'hF, 0, 4'hF, 4'hF);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
